// File: rtl/down_timer_pkg.sv
// Shared types and helpers for the programmable down-counting timer.
package down_timer_pkg;

  // Controller states: waiting for a start, or counting down.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of the prescaler counter; a divide-by-1 still needs one bit.
  function automatic int prescale_width(input int prescale);
    if (prescale <= 1) begin
      return 1;
    end else begin
      return $clog2(prescale);
    end
  endfunction

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a timer user (master) and the timer (slave).
interface down_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expired;

  modport master (
    output load, load_value, start, stop, periodic,
    input  count, busy, expired
  );

  modport slave (
    input  load, load_value, start, stop, periodic,
    output count, busy, expired
  );
endinterface

// File: rtl/down_timer_prescaler.sv
// Clock-enable divider: one tick every PRESCALE enabled cycles.
module tick_prescaler
  import down_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // With PRESCALE = 1 the counter stays at 0 and tick simply follows en.
  assign tick = en & (cnt_q == LAST);

  // Next phase: clear wins, otherwise advance and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Phase register, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Programmable down timer with one-shot and auto-reload modes.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  down_timer_if.slave  tmr_if
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             busy_q;
  logic             busy_d;
  logic             expired_q;
  logic             expired_d;
  logic [WIDTH-1:0] eff_reload_s;
  logic             pre_en_s;
  logic             pre_clr_s;
  logic             tick_s;

  // The prescaler only advances in RUN; a stop or leaving RUN resets its phase,
  // so every entry to RUN starts from a fresh phase.
  assign pre_en_s  = (state_q == RUN) & ~tmr_if.stop;
  assign pre_clr_s = ~pre_en_s;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en_s),
    .clr  (pre_clr_s),
    .tick (tick_s)
  );

  // A load in the same cycle as a start bypasses the reload register.
  assign eff_reload_s = tmr_if.load ? tmr_if.load_value : reload_q;

  // Next-state, count, reload and terminal-count decisions.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    reload_d  = tmr_if.load ? tmr_if.load_value : reload_q;

    case (state_q)
      IDLE: begin
        if (tmr_if.start && !tmr_if.stop) begin
          if (eff_reload_s != '0) begin
            count_d = eff_reload_s;
            state_d = RUN;
          end else begin
            // Zero period: report expiry straight away without running.
            count_d   = '0;
            expired_d = 1'b1;
          end
        end else if (tmr_if.load) begin
          count_d = tmr_if.load_value;
        end else begin
          count_d = count_q;
        end
      end
      RUN: begin
        if (tmr_if.stop) begin
          state_d = IDLE;
        end else if (tick_s) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (tmr_if.periodic) begin
            // Reload uses the register value, not a same-cycle load.
            count_d   = reload_q;
            expired_d = 1'b1;
          end else begin
            count_d   = '0;
            expired_d = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers, all cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign tmr_if.count   = count_q;
  assign tmr_if.busy    = busy_q;
  assign tmr_if.expired = expired_q;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: two instances (PRESCALE 1 and 2) driven in lockstep,
// checked every cycle against an elapsed-time model plus literal spot checks.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld  = 1'b0;
  logic [3:0] lv  = 4'd0;
  logic       st  = 1'b0;
  logic       sp  = 1'b0;
  logic       per = 1'b0;

  down_timer_if #(.WIDTH(4)) bus0 ();
  down_timer_if #(.WIDTH(4)) bus1 ();

  assign bus0.load       = ld;
  assign bus0.load_value = lv;
  assign bus0.start      = st;
  assign bus0.stop       = sp;
  assign bus0.periodic   = per;
  assign bus1.load       = ld;
  assign bus1.load_value = lv;
  assign bus1.start      = st;
  assign bus1.stop       = sp;
  assign bus1.periodic   = per;

  down_timer #(.WIDTH(4), .PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .tmr_if(bus0.slave));
  down_timer #(.WIDTH(4), .PRESCALE(2)) dut1 (.clk(clk), .rst(rst), .tmr_if(bus1.slave));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: while running, count = period - elapsed/PRESCALE; expiry when
  // elapsed reaches period*PRESCALE.
  int pre [2] = '{1, 2};
  bit m_run [2];
  int m_cnt [2];
  int m_rel [2];
  int m_base[2];
  int m_el  [2];
  bit m_exp [2];
  int per_seq[9] = '{4, 4, 3, 3, 2, 2, 1, 1, 4};

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int exp_count(input int k);
    return m_run[k] ? (m_base[k] - m_el[k] / pre[k]) : m_cnt[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_cnt[k] = 0; m_rel[k] = 0;
      m_base[k] = 0; m_el[k] = 0; m_exp[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int eff;
      bit exp_n;
      exp_n = 1'b0;
      if (m_run[k]) begin
        if (sp) begin
          m_cnt[k] = m_base[k] - m_el[k] / pre[k];
          m_run[k] = 1'b0;
        end else begin
          m_el[k]++;
          if (m_el[k] == m_base[k] * pre[k]) begin
            exp_n = 1'b1;
            if (per) begin
              m_el[k] = 0;
              m_base[k] = m_rel[k];
            end else begin
              m_run[k] = 1'b0;
              m_cnt[k] = 0;
            end
          end
        end
      end else begin
        eff = ld ? int'(lv) : m_rel[k];
        if (st && !sp) begin
          if (eff != 0) begin
            m_run[k] = 1'b1; m_base[k] = eff; m_el[k] = 0;
          end else begin
            m_cnt[k] = 0; exp_n = 1'b1;
          end
        end else if (ld) begin
          m_cnt[k] = int'(lv);
        end
      end
      if (ld) m_rel[k] = int'(lv);
      m_exp[k] = exp_n;
    end
  endtask

  task automatic compare();
    chk("dut0 count",   int'(bus0.count),   exp_count(0));
    chk("dut0 busy",    int'(bus0.busy),    int'(m_run[0]));
    chk("dut0 expired", int'(bus0.expired), int'(m_exp[0]));
    chk("dut1 count",   int'(bus1.count),   exp_count(1));
    chk("dut1 busy",    int'(bus1.busy),    int'(m_run[1]));
    chk("dut1 expired", int'(bus1.expired), int'(m_exp[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset count",   int'(bus0.count),   0);
    chk("reset busy",    int'(bus0.busy),    0);
    chk("reset expired", int'(bus0.expired), 0);
    @(negedge clk);
    rst = 1'b1;
    steps(2);

    // One-shot, reload 3.
    ld = 1'b1; lv = 4'd3; step();
    ld = 1'b0; st = 1'b1; step();
    st = 1'b0;
    chk("oneshot e0 count", int'(bus0.count), 3);
    chk("oneshot e0 busy",  int'(bus0.busy),  1);
    step(); chk("oneshot e1 count", int'(bus0.count), 2);
    step(); chk("oneshot e2 count", int'(bus0.count), 1);
    chk("oneshot e2 expired", int'(bus0.expired), 0);
    step();
    chk("oneshot e3 count",   int'(bus0.count),   0);
    chk("oneshot e3 expired", int'(bus0.expired), 1);
    chk("oneshot e3 busy",    int'(bus0.busy),    0);
    steps(4);

    // Periodic, reload 4, PRESCALE 2 sequence on dut1.
    ld = 1'b1; lv = 4'd4; step();
    ld = 1'b0; per = 1'b1; st = 1'b1; step();
    st = 1'b0;
    chk("periodic seq0", int'(bus1.count), per_seq[0]);
    for (int i = 1; i < 9; i++) begin
      step();
      chk("periodic seq", int'(bus1.count), per_seq[i]);
      chk("periodic expired", int'(bus1.expired), (i == 8) ? 1 : 0);
    end
    sp = 1'b1; step();
    sp = 1'b0; per = 1'b0;

    // Stop at count 2.
    ld = 1'b1; lv = 4'd5; step();
    ld = 1'b0; st = 1'b1; step();
    st = 1'b0; steps(3);
    chk("stop pre count", int'(bus0.count), 2);
    sp = 1'b1; step();
    sp = 1'b0;
    chk("stop count",   int'(bus0.count),   2);
    chk("stop busy",    int'(bus0.busy),    0);
    chk("stop expired", int'(bus0.expired), 0);
    steps(2);
    chk("stop hold count", int'(bus0.count), 2);

    // Start with reload 0.
    ld = 1'b1; lv = 4'd0; step();
    ld = 1'b0; st = 1'b1; step();
    st = 1'b0;
    chk("zero expired", int'(bus0.expired), 1);
    chk("zero busy",    int'(bus0.busy),    0);
    chk("zero count",   int'(bus0.count),   0);
    step();
    chk("zero expired gone", int'(bus0.expired), 0);

    // Load 9 together with start.
    ld = 1'b1; lv = 4'd9; st = 1'b1; step();
    ld = 1'b0; st = 1'b0;
    chk("bypass count", int'(bus0.count), 9);
    chk("bypass busy",  int'(bus0.busy),  1);
    sp = 1'b1; step();
    sp = 1'b0;

    // Load 6 during a periodic run with reload 3.
    ld = 1'b1; lv = 4'd3; step();
    ld = 1'b0; per = 1'b1; st = 1'b1; step();
    st = 1'b0; step();
    ld = 1'b1; lv = 4'd6; step();
    ld = 1'b0; step();
    chk("reload6 count",   int'(bus0.count),   6);
    chk("reload6 expired", int'(bus0.expired), 1);
    steps(5);
    chk("reload6 tail count", int'(bus0.count), 1);
    step();
    chk("reload6 second expired", int'(bus0.expired), 1);
    chk("reload6 second count",   int'(bus0.count),   6);
    sp = 1'b1; step();
    sp = 1'b0; per = 1'b0;

    // Start and stop together in IDLE.
    ld = 1'b1; lv = 4'd5; step();
    ld = 1'b0; st = 1'b1; sp = 1'b1; step();
    st = 1'b0; sp = 1'b0;
    chk("startstop busy",    int'(bus0.busy),    0);
    chk("startstop count",   int'(bus0.count),   5);
    chk("startstop expired", int'(bus0.expired), 0);
    step();

    // Maximum reload, one-shot.
    ld = 1'b1; lv = 4'd15; step();
    ld = 1'b0; st = 1'b1; step();
    st = 1'b0; steps(14);
    chk("max count1", int'(bus0.count), 1);
    step();
    chk("max count0",  int'(bus0.count),   0);
    chk("max expired", int'(bus0.expired), 1);
    chk("max busy",    int'(bus0.busy),    0);
    steps(20);
    chk("max no wrap dut0", int'(bus0.count), 0);
    chk("max no wrap dut1", int'(bus1.count), 0);

    // Asynchronous reset in the middle of a count.
    ld = 1'b1; lv = 4'd7; step();
    ld = 1'b0; st = 1'b1; step();
    st = 1'b0; steps(2);
    chk("rst pre count", int'(bus0.count), 5);
    #2 rst = 1'b0;
    #1;
    chk("rst dut0 count",   int'(bus0.count),   0);
    chk("rst dut0 busy",    int'(bus0.busy),    0);
    chk("rst dut0 expired", int'(bus0.expired), 0);
    chk("rst dut1 count",   int'(bus1.count),   0);
    chk("rst dut1 busy",    int'(bus1.busy),    0);
    chk("rst dut1 expired", int'(bus1.expired), 0);
    model_reset();
    step();
    @(negedge clk);
    rst = 1'b1;
    steps(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
